dbg_dump_ctrl: RTL
==================

Name: dbg_dump_ctrl

Overview:
- Parametrised debug-dump controller between uart_rx, the pipeline under test and the TX byte FIFO feeding uart_tx.
- On a received command byte it optionally single-steps the pipeline clock, snapshots NUM_WORDS debug words, and streams them as bytes into the FIFO.
- Unlike the fixed 34-word dumper, it honours FIFO back-pressure, has separate step and dump-only commands, and snapshots its data.

Parameters:
NUM_WORDS, 34, number of debug words per dump (PC, instruction, 32 registers by default); range 1..255
WORD_W, 32, width of each debug word in bits; must be a multiple of 8
STEP_CMD, 8'h41, command byte ("A"): step the pipeline once, then dump
DUMP_CMD, 8'h44, command byte ("D"): dump without stepping
SETTLE_CYCLES, 2, clk cycles waited after the step pulse before the snapshot; range 1..15

Ports:
clk  input  1  system clock (DCM output)
rst  input  1  asynchronous, active-high reset
rx_data  input  8  byte from uart_rx
rx_data_rdy  input  1  one-cycle strobe, rx_data valid
dump_data  input  NUM_WORDS*WORD_W  flattened debug bus; word k occupies bits [k*WORD_W +: WORD_W]
fifo_full  input  1  TX FIFO full
fifo_din  output  8  byte to the FIFO
fifo_wr_en  output  1  FIFO write strobe
step_clk  output  1  pipeline clock; high for exactly one clk cycle per step
busy  output  1  high in every state except IDLE
dump_done  output  1  one-cycle pulse when the last byte of a dump is written

Behaviour:
- Reset (async assert, release synchronous to clk):
  - state=IDLE.
  - fifo_din=0, fifo_wr_en=0, step_clk=0, busy=0, dump_done=0.
  - Byte index=0 and settle counter=0.
  - Reset mid-dump aborts the dump; bytes already written stay in the FIFO.
- Commands are sampled only when rx_data_rdy=1 in IDLE.
  - Strobes while busy are ignored. There is no queuing.
  - Other byte values are ignored.
  - A held rx_data with no new strobe never retriggers.
- States:
  - IDLE: on STEP_CMD go to STEP; on DUMP_CMD go to SNAP.
  - STEP: step_clk=1 for this one cycle; then go to SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles; then go to SNAP.
  - SNAP: register the whole dump_data into the snapshot; byte index=0; go to SEND.
  - SEND: emit bytes from the snapshot (rules below).
  - DONE: dump_done=1 for one cycle; return to IDLE.
- Byte order: word 0 first. Within a word, least significant byte first. Byte i = snapshot[i*8 +: 8], i = 0..NUM_WORDS*WORD_W/8-1.
- SEND handshake:
  - Each cycle with fifo_full=0: fifo_wr_en=1 with fifo_din=byte[index], and index increments.
  - Each cycle with fifo_full=1: fifo_wr_en=0 and index holds. fifo_din may hold any value.
  - fifo_wr_en and fifo_din are registered, and the FIFO full flag updates one cycle late. The controller therefore uses combinational fifo_full in the same cycle as the write decision, and the write decision is registered together with fifo_din.
  - Never write while fifo_full=1.
- Final byte: after writing byte TOTAL-1, go to DONE. fifo_wr_en must be low in DONE.
- Latency, no back-pressure:
  - STEP_CMD strobe: first write 3+SETTLE_CYCLES cycles after the strobe.
  - DUMP_CMD strobe: first write 2 cycles after the strobe.
  - Bytes are contiguous, one per cycle.
- Index counter width: $clog2(TOTAL+1), where TOTAL = NUM_WORDS*WORD_W/8. The index must not wrap inside a dump.
- Snapshot isolation: dump_data changes after SNAP must not affect the emitted bytes.
- step_clk is a plain registered output and is never gated combinationally.

Optional Feature:
- Macro DBG_DUMP_HEADER_EN.
- When defined, SEND first emits two header bytes: 0xA5, then an 8-bit frame counter. The counter resets to 0, increments after each DONE, and wraps 255->0.
  - Header bytes obey the same fifo_full rules.
  - TOTAL grows by 2.
- When undefined, no header is emitted, no counter flops exist, and the byte stream is payload only.

Test Plan:
- Parameters NUM_WORDS=2, WORD_W=32. dump_data={32'hDEADBEEF, 32'h00000404}. Pulse DUMP_CMD, fifo_full=0.
  -> Bytes 04 04 00 00 EF BE AD DE on 8 consecutive cycles.
  -> dump_done one cycle after the last byte. step_clk never high.
- Pulse STEP_CMD with SETTLE_CYCLES=2.
  -> step_clk high for exactly 1 cycle.
  -> First fifo_wr_en 5 cycles after the strobe. The snapshot reflects dump_data as of the SNAP cycle.
- Hold fifo_full=1 for cycles 3..6 of SEND.
  -> No writes while full; the stream resumes with the next unsent byte.
  -> All 8 bytes arrive exactly once, in order.
- Strobe DUMP_CMD again mid-dump, and strobe 8'h42 in IDLE.
  -> Both ignored: a single dump of 8 bytes, busy low after DONE.
- Assert rst after the 3rd byte.
  -> All outputs 0 immediately (async).
  -> After release, a new DUMP_CMD produces a full dump from byte 0.
- With DBG_DUMP_HEADER_EN, run 257 dumps.
  -> Each dump starts with A5 followed by the counter.
  -> Counter values 00..FF, then 00 on the 257th dump.

Source files
------------

// File: rtl/dbg_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dbg_dump_ctrl
// Purpose  : Debug-dump controller between uart_rx, the pipeline under test
//            and the TX byte FIFO feeding uart_tx. A received command byte
//            optionally single-steps the pipeline clock. The controller then
//            snapshots NUM_WORDS debug words and streams them into the FIFO
//            one byte per cycle: word 0 first, least significant byte first.
//            The stream pauses whenever the FIFO reports full.
// Ports    : clk          - system clock
//            rst          - asynchronous active-high reset
//            rx_data      - received byte from uart_rx
//            rx_data_rdy  - one-cycle strobe, rx_data valid
//            dump_data    - flattened debug bus, word k at [k*WORD_W +: WORD_W]
//            fifo_full    - TX FIFO full flag
//            fifo_din     - byte written to the FIFO (registered)
//            fifo_wr_en   - FIFO write strobe (registered)
//            step_clk     - pipeline clock, one clk cycle high per step
//            busy         - controller is not idle
//            dump_done    - one-cycle pulse after the last byte of a dump
// Options  : DBG_DUMP_HEADER_EN - when defined, each dump starts with two
//            header bytes: 0xA5 and then an 8-bit frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module dbg_dump_ctrl #(
  parameter int         NUM_WORDS     = 34,
  parameter int         WORD_W        = 32,
  parameter logic [7:0] STEP_CMD      = 8'h41,
  parameter logic [7:0] DUMP_CMD      = 8'h44,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_data_rdy,
  input  logic [NUM_WORDS*WORD_W-1:0] dump_data,
  input  logic                        fifo_full,
  output logic [7:0]                  fifo_din,
  output logic                        fifo_wr_en,
  output logic                        step_clk,
  output logic                        busy,
  output logic                        dump_done
);

  localparam int DATA_W    = NUM_WORDS * WORD_W;
  localparam int PAY_BYTES = DATA_W / 8;
`ifdef DBG_DUMP_HEADER_EN
  localparam int HDR_BYTES = 2;
`else
  localparam int HDR_BYTES = 0;
`endif
  localparam int TOTAL = PAY_BYTES + HDR_BYTES;
  // The index must be able to hold TOTAL itself. SEND spends one extra
  // cycle at index TOTAL so that the last registered write is on the bus
  // before DONE is entered.
  localparam int IDX_W = $clog2(TOTAL + 1);
  localparam logic [IDX_W-1:0] IDX_END     = IDX_W'(TOTAL);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  generate
    if ((WORD_W % 8) != 0 || WORD_W < 8) begin : g_bad_word_w
      $error("dbg_dump_ctrl: WORD_W must be a non-zero multiple of 8");
    end
    if (NUM_WORDS < 1 || NUM_WORDS > 255) begin : g_bad_num_words
      $error("dbg_dump_ctrl: NUM_WORDS must be in 1..255");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("dbg_dump_ctrl: SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STEP   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SNAP   = 3'd3,
    ST_SEND   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t              state_q,     state_d;
  logic [IDX_W-1:0]    idx_q,       idx_d;
  logic [3:0]          settle_q,    settle_d;
  logic [DATA_W-1:0]   snap_q,      snap_d;
  logic [7:0]          fifo_din_q,  fifo_din_d;
  logic                fifo_wr_q,   fifo_wr_d;
  logic                step_clk_q,  step_clk_d;
  logic                dump_done_q, dump_done_d;

  logic [IDX_W-1:0]    pay_idx;
  logic [7:0]          pay_byte;
  logic [7:0]          send_byte;

  // --------------------------------------------------------------------------
  // Byte selection from the snapshot
  // --------------------------------------------------------------------------
`ifdef DBG_DUMP_HEADER_EN
  logic [7:0] frame_q, frame_d;

  // The header occupies stream positions 0 and 1. At those positions the
  // payload index wraps past every valid payload byte, so it never aliases.
  assign pay_idx = idx_q - IDX_W'(HDR_BYTES);

  always_comb begin
    if (idx_q == IDX_W'(0)) begin
      send_byte = 8'hA5;
    end else if (idx_q == IDX_W'(1)) begin
      send_byte = frame_q;
    end else begin
      send_byte = pay_byte;
    end
  end

  // The frame counter advances once per completed dump and wraps 255 -> 0.
  always_comb begin
    frame_d = frame_q;
    if (state_q == ST_DONE) begin
      frame_d = frame_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= 8'h00;
    end else begin
      frame_q <= frame_d;
    end
  end
`else
  assign pay_idx   = idx_q;
  assign send_byte = pay_byte;
`endif

  always_comb begin
    pay_byte = 8'h00;
    for (int i = 0; i < PAY_BYTES; i++) begin
      if (pay_idx == IDX_W'(i)) begin
        pay_byte = snap_q[i*8 +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    settle_d    = settle_q;
    snap_d      = snap_q;
    fifo_din_d  = fifo_din_q;
    fifo_wr_d   = 1'b0;
    step_clk_d  = 1'b0;
    dump_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Commands are only looked at here. Strobes in any other state are
        // dropped, so there is no queuing.
        if (rx_data_rdy) begin
          if (rx_data == STEP_CMD) begin
            state_d = ST_STEP;
          end else if (rx_data == DUMP_CMD) begin
            state_d = ST_SNAP;
          end
        end
      end

      ST_STEP: begin
        settle_d = 4'd0;
        state_d  = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = 4'd0;
          state_d  = ST_SNAP;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      ST_SNAP: begin
        snap_d  = dump_data;
        idx_d   = '0;
        state_d = ST_SEND;
      end

      ST_SEND: begin
        if (idx_q == IDX_END) begin
          // The last byte is now on the bus. Finish without writing again.
          state_d = ST_DONE;
        end else if (!fifo_full) begin
          // The full flag is one cycle late, so the write decision uses the
          // live flag. The decision and the byte are registered together.
          fifo_wr_d  = 1'b1;
          fifo_din_d = send_byte;
          idx_d      = idx_q + IDX_W'(1);
        end
      end

      ST_DONE: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered so that step_clk and dump_done line up exactly with the
    // STEP and DONE state cycles.
    step_clk_d  = (state_d == ST_STEP);
    dump_done_d = (state_d == ST_DONE);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      settle_q    <= 4'd0;
      snap_q      <= '0;
      fifo_din_q  <= 8'h00;
      fifo_wr_q   <= 1'b0;
      step_clk_q  <= 1'b0;
      dump_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      settle_q    <= settle_d;
      snap_q      <= snap_d;
      fifo_din_q  <= fifo_din_d;
      fifo_wr_q   <= fifo_wr_d;
      step_clk_q  <= step_clk_d;
      dump_done_q <= dump_done_d;
    end
  end

  assign fifo_din   = fifo_din_q;
  assign fifo_wr_en = fifo_wr_q;
  assign step_clk   = step_clk_q;
  assign dump_done  = dump_done_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire
